// File: rtl/ew_pad_share_ctrl.sv
// Pad-bank sharing controller: hands one bank of user IO pads between co-resident designs
// with a tri-state / reset / settle / release sequence. Optional switch counter: PAD_SHARE_SWCOUNT_EN.
module ew_pad_share_ctrl #(
  parameter int NDESIGNS      = 4,
  parameter int NPADS         = 9,
  parameter int SELW          = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_la_invalid,
  input  logic                      i_reset_lock_a,
  input  logic                      i_reset_lock_b,
  input  logic [SELW-1:0]           i_sel,
  input  logic [NDESIGNS*NPADS-1:0] i_dsn_out,
  input  logic [NDESIGNS*NPADS-1:0] i_dsn_oeb,
  output logic [NDESIGNS*NPADS-1:0] o_dsn_in,
  output logic [NDESIGNS-1:0]       o_dsn_reset,
  input  logic [NPADS-1:0]          i_pad_in,
  output logic [NPADS-1:0]          o_pad_out,
  output logic [NPADS-1:0]          o_pad_oeb,
  output logic [SELW-1:0]           o_active,
  output logic                      o_busy
`ifdef PAD_SHARE_SWCOUNT_EN
  ,
  output logic [7:0]                o_switch_count
`endif
);

  localparam logic [1:0] ST_LOCKED  = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  localparam int CNTW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(SETTLE_CYCLES - 1);
  localparam logic [SELW:0]   NDES_W   = (SELW + 1)'(NDESIGNS);

  logic [SYNC_STAGES-1:0] a_sync, b_sync, inv_sync;
  logic [SELW-1:0]        sel_sync [SYNC_STAGES];

  // la_invalid synchroniser resets to 1 so the lock holds until real LA values arrive
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      a_sync   <= '0;
      b_sync   <= '0;
      inv_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) sel_sync[i] <= '0;
    end else begin
      a_sync   <= {a_sync[SYNC_STAGES-2:0], i_reset_lock_a};
      b_sync   <= {b_sync[SYNC_STAGES-2:0], i_reset_lock_b};
      inv_sync <= {inv_sync[SYNC_STAGES-2:0], i_la_invalid};
      sel_sync[0] <= i_sel;
      for (int i = 1; i < SYNC_STAGES; i++) sel_sync[i] <= sel_sync[i-1];
    end
  end

  logic            lock, sel_ok;
  logic [SELW-1:0] sel_s;

  assign sel_s  = sel_sync[SYNC_STAGES-1];
  assign lock   = (a_sync[SYNC_STAGES-1] == b_sync[SYNC_STAGES-1]) | inv_sync[SYNC_STAGES-1];
  assign sel_ok = ({1'b0, sel_s} < NDES_W);

  logic [1:0]      state, state_nx;
  logic [SELW-1:0] active, active_nx;
  logic [CNTW-1:0] cnt, cnt_nx;

  always_comb begin
    state_nx  = state;
    active_nx = active;
    cnt_nx    = cnt;
    if (lock) begin
      state_nx = ST_LOCKED;
      cnt_nx   = '0;
    end else begin
      case (state)
        ST_LOCKED: begin
          if (sel_ok) begin
            state_nx  = ST_RELEASE;
            active_nx = sel_s;
            cnt_nx    = CNT_LOAD;
          end
        end
        ST_RELEASE: begin
          if (cnt == '0) state_nx = ST_ACTIVE;
          else           cnt_nx   = cnt - 1'b1;
        end
        ST_ACTIVE: begin
          if (sel_s != active) begin
            state_nx = ST_DRAIN;
            cnt_nx   = CNT_LOAD;
          end
        end
        default: begin
          // DRAIN: the selector is only looked at again once the drain time has elapsed
          if (cnt != '0) begin
            cnt_nx = cnt - 1'b1;
          end else if (!sel_ok) begin
            state_nx = ST_LOCKED;
          end else begin
            state_nx  = ST_RELEASE;
            active_nx = sel_s;
            cnt_nx    = CNT_LOAD;
          end
        end
      endcase
    end
  end

  logic [NDESIGNS*NPADS-1:0] dsn_in_nx;
  logic [NDESIGNS-1:0]       dsn_reset_nx;
  logic [NPADS-1:0]          pad_out_nx, pad_oeb_nx;

  // Outputs are derived from the next state so they change on the edge that enters it
  always_comb begin
    dsn_in_nx    = '0;
    dsn_reset_nx = '1;
    pad_out_nx   = '0;
    pad_oeb_nx   = '1;
    if (state_nx == ST_ACTIVE) begin
      pad_out_nx = i_dsn_out[int'(active_nx)*NPADS +: NPADS];
      pad_oeb_nx = i_dsn_oeb[int'(active_nx)*NPADS +: NPADS];
      dsn_in_nx[int'(active_nx)*NPADS +: NPADS] = i_pad_in;
      dsn_reset_nx[active_nx] = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_LOCKED;
      active      <= '0;
      cnt         <= '0;
      o_dsn_in    <= '0;
      o_dsn_reset <= '1;
      o_pad_out   <= '0;
      o_pad_oeb   <= '1;
    end else begin
      state       <= state_nx;
      active      <= active_nx;
      cnt         <= cnt_nx;
      o_dsn_in    <= dsn_in_nx;
      o_dsn_reset <= dsn_reset_nx;
      o_pad_out   <= pad_out_nx;
      o_pad_oeb   <= pad_oeb_nx;
    end
  end

  assign o_active = active;
  assign o_busy   = (state != ST_ACTIVE);

`ifdef PAD_SHARE_SWCOUNT_EN
  // Counts completed handovers; survives lock, cleared only by the pin reset
  logic [7:0] sw_cnt;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sw_cnt <= '0;
    end else if (state == ST_RELEASE && state_nx == ST_ACTIVE && sw_cnt != 8'hFF) begin
      sw_cnt <= sw_cnt + 8'd1;
    end
  end
  assign o_switch_count = sw_cnt;
`else
  // Switch counter not built in this configuration.
`endif

endmodule

// File: tb/tb_ew_pad_share_ctrl.sv
// Directed bench for ew_pad_share_ctrl: a default 4-design instance plus a 3-design
// instance for the out-of-range selector case. Define PAD_SHARE_SWCOUNT_EN to cover the counter.
module tb_ew_pad_share_ctrl;
  localparam int ND = 4;
  localparam int NP = 9;
  localparam int N3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, la_invalid, lock_a, lock_b;
  logic [1:0]    sel, sel3;
  logic [ND*NP-1:0] dsn_out, dsn_oeb, dsn_in;
  logic [ND-1:0] dsn_reset;
  logic [NP-1:0] pad_in, pad_out, pad_oeb;
  logic [1:0]    active;
  logic          busy;

  logic [N3*NP-1:0] dsn_out3, dsn_oeb3, dsn_in3;
  logic [N3-1:0] dsn_reset3;
  logic [NP-1:0] pad_out3, pad_oeb3;
  logic [1:0]    active3;
  logic          busy3;
`ifdef PAD_SHARE_SWCOUNT_EN
  logic [7:0]    sw_count, sw_count3;
`endif

  ew_pad_share_ctrl dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_la_invalid(la_invalid),
    .i_reset_lock_a(lock_a), .i_reset_lock_b(lock_b), .i_sel(sel),
    .i_dsn_out(dsn_out), .i_dsn_oeb(dsn_oeb), .o_dsn_in(dsn_in), .o_dsn_reset(dsn_reset),
    .i_pad_in(pad_in), .o_pad_out(pad_out), .o_pad_oeb(pad_oeb),
    .o_active(active), .o_busy(busy)
`ifdef PAD_SHARE_SWCOUNT_EN
    , .o_switch_count(sw_count)
`endif
  );

  ew_pad_share_ctrl #(.NDESIGNS(N3), .SETTLE_CYCLES(4)) dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_la_invalid(la_invalid),
    .i_reset_lock_a(lock_a), .i_reset_lock_b(lock_b), .i_sel(sel3),
    .i_dsn_out(dsn_out3), .i_dsn_oeb(dsn_oeb3), .o_dsn_in(dsn_in3), .o_dsn_reset(dsn_reset3),
    .i_pad_in(pad_in), .o_pad_out(pad_out3), .o_pad_oeb(pad_oeb3),
    .o_active(active3), .o_busy(busy3)
`ifdef PAD_SHARE_SWCOUNT_EN
    , .o_switch_count(sw_count3)
`endif
  );

  int errors = 0;
  int checks = 0;
  logic [NP-1:0] exp_q[$];

  // Clock: every step lands 1 ns after a rising edge, so drive and sample there.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; la_invalid = 1'b0; lock_a = 1'b0; lock_b = 1'b0;
    sel = 2'd0; sel3 = 2'd3; pad_in = 9'h15A;
    dsn_out  = {9'h088, 9'h144, 9'h022, 9'h011};
    dsn_oeb  = {9'h155, 9'h00F, 9'h0F1, 9'h1F0};
    dsn_out3 = {9'h0AB, 9'h0CD, 9'h0EF};
    dsn_oeb3 = {9'h001, 9'h002, 9'h003};
    tick(2);
    rst_n = 1'b1;
    for (int t = 0; t < 100; t++) begin
      tick(1);
      if ({busy, dsn_reset, pad_oeb, pad_out, active} !== {1'b1, 4'hF, 9'h1FF, 9'h000, 2'd0}) begin
        errors++;
        $display("FAIL reset_hold t=%0d: busy=%b rst=%b oeb=%h out=%h act=%0d, need 1 1111 1ff 000 0",
                 t, busy, dsn_reset, pad_oeb, pad_out, active);
      end
      checks++;
    end
    if (dsn_in !== '0) begin
      errors++; $display("FAIL reset_dsn_in: got %h need 0", dsn_in);
    end
    checks++;
  endtask

  task automatic test_first_owner();
    sel = 2'd2; lock_b = 1'b1;
    tick(18);
    if (busy !== 1'b1) begin
      errors++; $display("FAIL unlock_early: busy=%b at 18 clocks, need 1", busy);
    end
    checks++;
    tick(1);
    if ({busy, active, dsn_reset} !== {1'b0, 2'd2, 4'b1011}) begin
      errors++; $display("FAIL unlock_active: busy=%b act=%0d rst=%b, need 0 2 1011", busy, active, dsn_reset);
    end
    checks++;
    if ({pad_out, pad_oeb} !== {9'h144, 9'h00F}) begin
      errors++; $display("FAIL route_d2: out=%h oeb=%h, need 144 00f", pad_out, pad_oeb);
    end
    checks++;
    if (dsn_in !== {9'h000, 9'h15A, 9'h000, 9'h000}) begin
      errors++; $display("FAIL dsn_in_d2: got %h need %h", dsn_in, {9'h000, 9'h15A, 9'h000, 9'h000});
    end
    checks++;
  endtask

  task automatic test_pad_data();
    logic [NP-1:0] vals [4];
    logic [NP-1:0] e;
    vals[0] = 9'h1A5; vals[1] = 9'h05A; vals[2] = 9'h1FF; vals[3] = 9'h000;
    for (int i = 0; i < 4; i++) begin
      pad_in = vals[i];
      exp_q.push_back(vals[i]);
      tick(1);
      e = exp_q.pop_front();
      if (dsn_in !== {9'h000, e, 9'h000, 9'h000}) begin
        errors++; $display("FAIL pad_in_path i=%0d: got %h need slot2=%h", i, dsn_in, e);
      end
      checks++;
    end
    dsn_out[2*NP +: NP] = 9'h0C3;
    tick(1);
    if (pad_out !== 9'h0C3) begin
      errors++; $display("FAIL pad_out_path: got %h need 0c3", pad_out);
    end
    checks++;
    dsn_out[2*NP +: NP] = 9'h144;
    tick(1);
  endtask

  task automatic test_switch();
    logic exp_busy;
    sel = 2'd1;
    for (int t = 1; t <= 36; t++) begin
      tick(1);
      exp_busy = (t >= 3 && t < 35);
      if (busy !== exp_busy) begin
        errors++; $display("FAIL switch_busy t=%0d: got %b need %b", t, busy, exp_busy);
      end
      checks++;
      if ($countones(~dsn_reset) > 1 || (exp_busy && {dsn_reset, pad_oeb} !== {4'hF, 9'h1FF})) begin
        errors++; $display("FAIL switch_overlap t=%0d: rst=%b oeb=%h", t, dsn_reset, pad_oeb);
      end
      checks++;
    end
    if ({active, dsn_reset, pad_out, pad_oeb} !== {2'd1, 4'b1101, 9'h022, 9'h0F1}) begin
      errors++; $display("FAIL switch_to_d1: act=%0d rst=%b out=%h oeb=%h, need 1 1101 022 0f1",
                         active, dsn_reset, pad_out, pad_oeb);
    end
    checks++;
  endtask

  task automatic test_lock_abort();
    sel = 2'd3;
    tick(8);
    lock_a = 1'b1;
    tick(3);
    lock_a = 1'b0;
    tick(18);
    if ({busy, dsn_reset} !== {1'b1, 4'hF}) begin
      errors++; $display("FAIL abort_relock: busy=%b rst=%b at 18, need 1 1111", busy, dsn_reset);
    end
    checks++;
    tick(1);
    if ({busy, active, dsn_reset, pad_out} !== {1'b0, 2'd3, 4'b0111, 9'h088}) begin
      errors++; $display("FAIL abort_rerelease: busy=%b act=%0d rst=%b out=%h, need 0 3 0111 088",
                         busy, active, dsn_reset, pad_out);
    end
    checks++;
  endtask

  task automatic test_la_invalid();
    la_invalid = 1'b1;
    tick(2);
    if (busy !== 1'b0) begin
      errors++; $display("FAIL inv_sync_delay: busy=%b, need 0", busy);
    end
    checks++;
    tick(1);
    if ({busy, dsn_reset, pad_oeb} !== {1'b1, 4'hF, 9'h1FF}) begin
      errors++; $display("FAIL inv_lock: busy=%b rst=%b oeb=%h, need 1 1111 1ff", busy, dsn_reset, pad_oeb);
    end
    checks++;
    sel = 2'd0;
    tick(5);
    la_invalid = 1'b0;
    tick(18);
    if (busy !== 1'b1) begin
      errors++; $display("FAIL inv_release_early: busy=%b, need 1", busy);
    end
    checks++;
    tick(1);
    if ({busy, active, dsn_reset} !== {1'b0, 2'd0, 4'b1110}) begin
      errors++; $display("FAIL inv_release: busy=%b act=%0d rst=%b, need 0 0 1110", busy, active, dsn_reset);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    if ({busy, dsn_reset, pad_oeb, pad_out, dsn_in} !== {1'b1, 4'hF, 9'h1FF, 9'h000, 36'h0}) begin
      errors++; $display("FAIL async_reset: busy=%b rst=%b oeb=%h out=%h in=%h", busy, dsn_reset, pad_oeb, pad_out, dsn_in);
    end
    checks++;
`ifdef PAD_SHARE_SWCOUNT_EN
    if (sw_count !== 8'd0) begin
      errors++; $display("FAIL async_reset_count: got %0d need 0", sw_count);
    end
    checks++;
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(18);
    if (busy !== 1'b1) begin
      errors++; $display("FAIL post_reset_early: busy=%b, need 1", busy);
    end
    checks++;
    tick(1);
    if ({busy, active, dsn_reset} !== {1'b0, 2'd0, 4'b1110}) begin
      errors++; $display("FAIL post_reset_active: busy=%b act=%0d rst=%b, need 0 0 1110", busy, active, dsn_reset);
    end
    checks++;
  endtask

  task automatic test_out_of_range();
    if ({busy3, dsn_reset3, pad_oeb3} !== {1'b1, 3'b111, 9'h1FF}) begin
      errors++; $display("FAIL oor_locked: busy=%b rst=%b oeb=%h, need 1 111 1ff", busy3, dsn_reset3, pad_oeb3);
    end
    checks++;
    sel3 = 2'd0;
    tick(6);
    if (busy3 !== 1'b1) begin
      errors++; $display("FAIL oor_release_early: busy=%b, need 1", busy3);
    end
    checks++;
    tick(1);
    if ({busy3, active3, dsn_reset3, pad_out3} !== {1'b0, 2'd0, 3'b110, 9'h0EF}) begin
      errors++; $display("FAIL oor_active0: busy=%b act=%0d rst=%b out=%h, need 0 0 110 0ef",
                         busy3, active3, dsn_reset3, pad_out3);
    end
    checks++;
    sel3 = 2'd3;
    for (int t = 1; t <= 20; t++) begin
      tick(1);
      if ({busy3, dsn_reset3} !== ((t < 3) ? {1'b0, 3'b110} : {1'b1, 3'b111})) begin
        errors++; $display("FAIL oor_drain_lock t=%0d: busy=%b rst=%b", t, busy3, dsn_reset3);
      end
      checks++;
    end
  endtask

`ifdef PAD_SHARE_SWCOUNT_EN
  task automatic test_switch_count();
    if (sw_count !== 8'd1) begin
      errors++; $display("FAIL count_start: got %0d need 1", sw_count);
    end
    checks++;
    for (int i = 0; i < 300; i++) begin
      lock_a = 1'b1;
      tick(3);
      lock_a = 1'b0;
      tick(19);
    end
    if (sw_count !== 8'd255) begin
      errors++; $display("FAIL count_saturate: got %0d need 255", sw_count);
    end
    checks++;
    lock_a = 1'b1;
    tick(6);
    if ({busy, sw_count} !== {1'b1, 8'd255}) begin
      errors++; $display("FAIL count_lock_keep: busy=%b count=%0d, need 1 255", busy, sw_count);
    end
    checks++;
    rst_n = 1'b0;
    #1;
    if (sw_count !== 8'd0) begin
      errors++; $display("FAIL count_reset_clear: got %0d need 0", sw_count);
    end
    checks++;
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_first_owner();
    test_pad_data();
    test_switch();
    test_lock_abort();
    test_la_invalid();
    test_async_reset();
    test_out_of_range();
`ifdef PAD_SHARE_SWCOUNT_EN
    test_switch_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
